seven_seg_multi: RTL

- Pixel-stream renderer drawing a row of N hex digits as seven-segment glyphs on the LCD, for trip-computer readouts (speed, distance, time).
- Sits between the LCD timing generator (x, y, de) and the pixel colour mux; pix_out selects the foreground colour.
- Adds registered output, an internal hex decoder, a per-digit write port and tear-free frame-boundary commit.
- Also adds leading-zero blanking and per-digit decimal points.

---
 rtl/seven_seg_multi.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_multi.sv
// Seven-segment pixel renderer for a row of DIGITS hex digits, 2-cycle registered output.
// Optional blinking digits when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_multi #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned W      = 12,
  parameter int unsigned H      = 52,
  parameter int unsigned GAP    = 8,
  parameter int unsigned X0     = 16,
  parameter int unsigned Y0     = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        x,
  input  logic [8:0]        y,
  input  logic              de,
  input  logic              frame_start,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [3:0]        wr_val,
  input  logic              wr_dp,
  input  logic              lz_blank,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [DIGITS-1:0] blink_mask,
`endif
  output logic              pix_out,
  output logic              pix_valid
);

  localparam int unsigned CW  = H + W + 1 + GAP;
  localparam int unsigned GH  = 2 * H + W + 2;
  localparam int unsigned CXW = $clog2(CW);
  localparam int unsigned DIW = $clog2(DIGITS + 1);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;  4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;  4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;  4'hE: hex7 = 7'h4F;  4'hF: hex7 = 7'h47;
    endcase
  endfunction

  // Stage 1: column/row tracking
  logic [CXW-1:0] cx_q, cx_d;
  logic [DIW-1:0] di_q, di_d;
  logic [8:0]     ly_q, ly_d;
  logic           in_row_q, in_row_d, de_q;

  always_comb begin
    cx_d = cx_q;
    di_d = di_q;
    if (de) begin
      if (x == 9'(X0)) begin
        cx_d = '0;
        di_d = '0;
      end else if (cx_q == CXW'(CW - 1)) begin
        cx_d = '0;
        if (di_q != DIW'(DIGITS)) di_d = di_q + DIW'(1);
      end else begin
        cx_d = cx_q + CXW'(1);
      end
    end
    ly_d     = y - 9'(Y0);
    in_row_d = (y >= 9'(Y0)) && (ly_d < 9'(GH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q     <= '0;
      di_q     <= DIW'(DIGITS);
      ly_q     <= '0;
      in_row_q <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      cx_q     <= cx_d;
      di_q     <= di_d;
      ly_q     <= ly_d;
      in_row_q <= in_row_d;
      de_q     <= de;
    end
  end

  // Staging and display buffers
  logic [3:0]        stg_val_q [DIGITS];
  logic [3:0]        stg_val_d [DIGITS];
  logic [3:0]        disp_val_q[DIGITS];
  logic [DIGITS-1:0] stg_dp_q, stg_dp_d, disp_dp_q;
  logic              lz_q, disp_ok_q;

  always_comb begin
    stg_val_d = stg_val_q;
    stg_dp_d  = stg_dp_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (wr_en && (32'(wr_idx) == i)) begin
        stg_val_d[i] = wr_val;
        stg_dp_d[i]  = wr_dp;
      end
    end
  end

  // disp_ok_q keeps the cleared display dark until the first commit after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_val_q  <= '{default: '0};
      disp_val_q <= '{default: '0};
      stg_dp_q   <= '0;
      disp_dp_q  <= '0;
      lz_q       <= 1'b0;
      disp_ok_q  <= 1'b0;
    end else begin
      stg_val_q <= stg_val_d;
      stg_dp_q  <= stg_dp_d;
      if (frame_start) begin
        disp_val_q <= stg_val_d;
        disp_dp_q  <= stg_dp_d;
        lz_q       <= lz_blank;
        disp_ok_q  <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  logic [4:0]        frame_cnt_q;
  logic [DIGITS-1:0] blink_q;

  // The mask is captured straight from the port at the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      blink_q     <= '0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
      blink_q     <= blink_mask;
    end
  end
`endif

  // Per-digit mask {a,b,c,d,e,f,g,dp}
  logic [7:0] dmask [DIGITS];
  logic       lead, blank;

  always_comb begin
    lead  = lz_q;
    blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      blank    = lead && (disp_val_q[i] == 4'h0) && (i != DIGITS - 1);
      lead     = blank;
      dmask[i] = blank ? {7'b0, disp_dp_q[i]} : {hex7(disp_val_q[i]), disp_dp_q[i]};
`ifdef SEVEN_SEG_BLINK_EN
      if (frame_cnt_q[4] && blink_q[i]) dmask[i] = '0;
`endif
      if (!disp_ok_q) dmask[i] = '0;
    end
  end

  // Stage 2: segment hit test
  int unsigned lx, ly;
  logic [7:0]  seg_hit, sel_mask;
  logic        acol, pix_d;

  always_comb begin
    lx   = 32'(cx_q);
    ly   = 32'(ly_q);
    acol = (lx >= W / 2) && (lx < W / 2 + H);
    seg_hit[7] = acol && (ly < W);
    seg_hit[6] = (lx >= H + 1) && (lx < H + 1 + W) && (ly >= W / 2) && (ly < W / 2 + H);
    seg_hit[5] = (lx >= H + 1) && (lx < H + 1 + W) &&
                 (ly >= H + W / 2 + 1) && (ly < 2 * H + W / 2 + 1);
    seg_hit[4] = acol && (ly >= 2 * H + 2) && (ly < 2 * H + 2 + W);
    seg_hit[3] = (lx < W) && (ly >= H + W / 2 + 1) && (ly < 2 * H + W / 2 + 1);
    seg_hit[2] = (lx < W) && (ly >= W / 2) && (ly < W / 2 + H);
    seg_hit[1] = acol && (ly >= H + 1) && (ly < H + 1 + W);
    seg_hit[0] = (lx >= H + W + 2) && (lx < H + W + 2 + W / 2) &&
                 (ly >= 2 * H + 2) && (ly < 2 * H + 2 + W);
    sel_mask = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (32'(di_q) == i) sel_mask = dmask[i];
    end
    pix_d = de_q && in_row_q && (di_q != DIW'(DIGITS)) && (|(seg_hit & sel_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out   <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      pix_out   <= pix_d;
      pix_valid <= de_q;
    end
  end

endmodule
